// File: rtl/cpu_pkg.sv
// Shared decode/execute definitions: forward-source codes, latch FSM states, default widths.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;
endpackage

// File: rtl/forward_select.sv
// Per-operand bypass select: EX > MEM > WB > register file; r0 is never forwarded.
module forward_select #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] sx,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [REG_AW-1:0] ex_sc,
    input  logic              ex_rfl,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_AW-1:0] mem_sc,
    input  logic              mem_rfl,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [REG_AW-1:0] wb_sc,
    input  logic              wb_rfl,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        fwd
);
    import cpu_pkg::*;

    always_comb begin
        data = rf_data;
        fwd  = FWD_RF;
        if (sx != '0) begin
            if (ex_rfl && ex_sc == sx) begin
                data = ex_result;
                fwd  = FWD_EX;
            end else if (mem_rfl && mem_sc == sx) begin
                data = mem_result;
                fwd  = FWD_MEM;
            end else if (wb_rfl && wb_sc == sx) begin
                // RF writes on the same edge decode reads, so its PA/PB is stale here
                data = wb_result;
                fwd  = FWD_WB;
            end
        end
    end
endmodule

// File: rtl/operand_forward_latch.sv
// Decode->EX boundary: operand bypass, load-use stall/bubble, flush/hold, stall counter.
module operand_forward_latch #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic [DATA_W-1:0] in_PA,
    input  logic [DATA_W-1:0] in_PB,
    input  logic [REG_AW-1:0] in_SA,
    input  logic [REG_AW-1:0] in_SB,
    input  logic              in_useA,
    input  logic              in_useB,
    input  logic [REG_AW-1:0] in_SD,
    input  logic              in_RFL_id,
    input  logic              in_load_id,
    input  logic              in_valid_id,
    input  logic [DATA_W-1:0] in_ex_result,
    input  logic [REG_AW-1:0] in_ex_SC,
    input  logic              in_ex_RFL,
    input  logic              in_ex_load,
    input  logic [DATA_W-1:0] in_mem_result,
    input  logic [REG_AW-1:0] in_mem_SC,
    input  logic              in_mem_RFL,
    input  logic [DATA_W-1:0] in_PC,
    input  logic [REG_AW-1:0] in_SC,
    input  logic              in_RFL,
    input  logic              in_flush,
    input  logic              in_hold,
    output logic [DATA_W-1:0] out_A,
    output logic [DATA_W-1:0] out_B,
    output logic [REG_AW-1:0] out_SC,
    output logic              out_RFL,
    output logic              out_load,
    output logic              out_valid,
    output logic [1:0]        out_fwdA,
    output logic [1:0]        out_fwdB,
    output logic              out_stall,
    output logic [CNT_W-1:0]  out_stall_cnt
);
    import cpu_pkg::*;

    localparam int NUM_OPS = 2;

    logic [NUM_OPS-1:0][REG_AW-1:0] op_sx;
    logic [NUM_OPS-1:0][DATA_W-1:0] op_rf;
    logic [NUM_OPS-1:0][DATA_W-1:0] op_data;
    logic [NUM_OPS-1:0][1:0]        op_fwd;

    assign op_sx = {in_SB, in_SA};
    assign op_rf = {in_PB, in_PA};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
        forward_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fs (
            .sx         (op_sx[i]),
            .rf_data    (op_rf[i]),
            .ex_result  (in_ex_result),
            .ex_sc      (in_ex_SC),
            .ex_rfl     (in_ex_RFL),
            .mem_result (in_mem_result),
            .mem_sc     (in_mem_SC),
            .mem_rfl    (in_mem_RFL),
            .wb_result  (in_PC),
            .wb_sc      (in_SC),
            .wb_rfl     (in_RFL),
            .data       (op_data[i]),
            .fwd        (op_fwd[i])
        );
    end

    state_t state, state_nxt;
    logic   haz, latch_en, bubble, cnt_inc;

    // Masked in LU_STALL: EX then holds the bubble, the load has moved to MEM
    assign haz = (state == RUN) && in_valid_id && in_ex_load && in_ex_RFL && (in_ex_SC != '0) &&
                 ((in_useA && in_SA == in_ex_SC) || (in_useB && in_SB == in_ex_SC));

    assign out_stall = haz && !in_flush && !in_reset;

    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        bubble    = 1'b0;
        cnt_inc   = 1'b0;
        if (in_flush) begin
            bubble    = 1'b1;
            state_nxt = RUN;
        end else if (!in_hold) begin
            if (haz) begin
                bubble    = 1'b1;
                cnt_inc   = 1'b1;
                state_nxt = LU_STALL;
            end else begin
                latch_en  = 1'b1;
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state         <= RUN;
            out_A         <= '0;
            out_B         <= '0;
            out_SC        <= '0;
            out_RFL       <= 1'b0;
            out_load      <= 1'b0;
            out_valid     <= 1'b0;
            out_fwdA      <= FWD_RF;
            out_fwdB      <= FWD_RF;
            out_stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (bubble) begin
                out_A     <= '0;
                out_B     <= '0;
                out_SC    <= '0;
                out_RFL   <= 1'b0;
                out_load  <= 1'b0;
                out_valid <= 1'b0;
                out_fwdA  <= FWD_RF;
                out_fwdB  <= FWD_RF;
            end else if (latch_en) begin
                out_A     <= op_data[0];
                out_B     <= op_data[1];
                out_SC    <= in_SD;
                out_RFL   <= in_RFL_id;
                out_load  <= in_load_id;
                out_valid <= in_valid_id;
                out_fwdA  <= op_fwd[0];
                out_fwdB  <= op_fwd[1];
            end
            if (cnt_inc && out_stall_cnt != '1)
                out_stall_cnt <= out_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_operand_forward_latch.sv
// Directed bench for operand_forward_latch: bypass priority, r0, load-use, flush, hold, reset.
module tb_operand_forward_latch;
    logic        in_clk = 1'b0;
    logic        in_reset;
    logic [31:0] in_PA, in_PB, in_ex_result, in_mem_result, in_PC;
    logic [4:0]  in_SA, in_SB, in_SD, in_ex_SC, in_mem_SC, in_SC;
    logic        in_useA, in_useB, in_RFL_id, in_load_id, in_valid_id;
    logic        in_ex_RFL, in_ex_load, in_mem_RFL, in_RFL, in_flush, in_hold;
    logic [31:0] out_A, out_B;
    logic [4:0]  out_SC;
    logic        out_RFL, out_load, out_valid, out_stall;
    logic [1:0]  out_fwdA, out_fwdB;
    logic [15:0] out_stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 in_clk = ~in_clk;

    operand_forward_latch dut (
        .in_clk(in_clk), .in_reset(in_reset),
        .in_PA(in_PA), .in_PB(in_PB), .in_SA(in_SA), .in_SB(in_SB),
        .in_useA(in_useA), .in_useB(in_useB), .in_SD(in_SD),
        .in_RFL_id(in_RFL_id), .in_load_id(in_load_id), .in_valid_id(in_valid_id),
        .in_ex_result(in_ex_result), .in_ex_SC(in_ex_SC), .in_ex_RFL(in_ex_RFL), .in_ex_load(in_ex_load),
        .in_mem_result(in_mem_result), .in_mem_SC(in_mem_SC), .in_mem_RFL(in_mem_RFL),
        .in_PC(in_PC), .in_SC(in_SC), .in_RFL(in_RFL),
        .in_flush(in_flush), .in_hold(in_hold),
        .out_A(out_A), .out_B(out_B), .out_SC(out_SC), .out_RFL(out_RFL),
        .out_load(out_load), .out_valid(out_valid), .out_fwdA(out_fwdA), .out_fwdB(out_fwdB),
        .out_stall(out_stall), .out_stall_cnt(out_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // inputs change 1 time unit after the edge, outputs sampled well before the next one
    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic clr();
        in_PA = '0; in_PB = '0; in_SA = '0; in_SB = '0; in_useA = 0; in_useB = 0;
        in_SD = '0; in_RFL_id = 0; in_load_id = 0; in_valid_id = 1;
        in_ex_result = '0; in_ex_SC = '0; in_ex_RFL = 0; in_ex_load = 0;
        in_mem_result = '0; in_mem_SC = '0; in_mem_RFL = 0;
        in_PC = '0; in_SC = '0; in_RFL = 0; in_flush = 0; in_hold = 0;
    endtask

    task automatic set_ld_use();
        in_ex_load = 1; in_ex_RFL = 1; in_ex_SC = 5; in_ex_result = 32'hDEAD;
        in_SB = 5; in_useB = 1; in_PB = 32'h77; in_SD = 9; in_RFL_id = 1;
    endtask

    initial begin
        clr();
        in_reset = 1;
        set_ld_use();
        tick(); tick();
        chk("rst_stall", out_stall, 0);
        chk("rst_A", out_A, 0);
        chk("rst_B", out_B, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ctl", {out_SC, out_RFL, out_load, out_fwdA, out_fwdB}, 0);
        chk("rst_cnt", out_stall_cnt, 0);
        in_reset = 0;
        clr();

        // bypass priority on operand A
        in_SA = 3; in_useA = 1; in_PA = 32'h99; in_SD = 7; in_RFL_id = 1;
        in_ex_RFL = 1; in_ex_SC = 3; in_ex_result = 32'h11;
        in_mem_RFL = 1; in_mem_SC = 3; in_mem_result = 32'h22;
        in_RFL = 1; in_SC = 3; in_PC = 32'h33;
        tick();
        chk("ex_A", out_A, 32'h11);
        chk("ex_fwdA", out_fwdA, 2'b01);
        chk("ex_ctl", {out_valid, out_RFL, out_SC}, {1'b1, 1'b1, 5'd7});
        in_ex_RFL = 0;
        tick();
        chk("mem_A", out_A, 32'h22);
        chk("mem_fwdA", out_fwdA, 2'b10);
        in_mem_RFL = 0;
        tick();
        chk("wb_A", out_A, 32'h33);
        chk("wb_fwdA", out_fwdA, 2'b11);
        in_RFL = 0;
        tick();
        chk("rf_A", out_A, 32'h99);
        chk("rf_fwdA", out_fwdA, 2'b00);

        // r0 is never forwarded
        clr();
        in_SA = 0; in_useA = 1; in_PA = 32'h1234;
        in_ex_RFL = 1; in_ex_SC = 0; in_ex_result = 32'h55;
        tick();
        chk("r0_A", out_A, 32'h1234);
        chk("r0_fwdA", out_fwdA, 2'b00);

        // load-use on B: one bubble, then MEM bypass
        clr();
        set_ld_use();
        #1 chk("lu_stall", out_stall, 1);
        tick();
        chk("lu_valid", out_valid, 0);
        chk("lu_B", out_B, 0);
        chk("lu_cnt", out_stall_cnt, 1);
        in_ex_RFL = 0; in_ex_load = 0;
        in_mem_RFL = 1; in_mem_SC = 5; in_mem_result = 32'hCAFE;
        #1 chk("lu2_stall", out_stall, 0);
        tick();
        chk("lu2_B", out_B, 32'hCAFE);
        chk("lu2_fwdB", out_fwdB, 2'b10);
        chk("lu2_ctl", {out_valid, out_SC}, {1'b1, 5'd9});

        // SB matches the load but is unused: no stall
        clr();
        set_ld_use();
        in_useB = 0; in_SA = 2; in_useA = 1; in_PA = 32'h44;
        #1 chk("nouse_stall", out_stall, 0);
        tick();
        chk("nouse_valid", out_valid, 1);
        chk("nouse_A", out_A, 32'h44);
        chk("nouse_cnt", out_stall_cnt, 1);

        // flush during a hazard: bubble, no stall, counter untouched
        in_useB = 1; in_flush = 1;
        #1 chk("fl_stall", out_stall, 0);
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_A", out_A, 0);
        chk("fl_cnt", out_stall_cnt, 1);
        in_flush = 0;
        #1 chk("fl_run", out_stall, 1);

        // latch a known instruction, then hold 3 cycles with a hazard pending
        in_useB = 0; in_SD = 4;
        tick();
        chk("pre_hold_A", out_A, 32'h44);
        in_hold = 1; in_useB = 1; in_PA = 32'h66; in_SD = 12;
        #1 chk("hold_stall", out_stall, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_A", out_A, 32'h44);
            chk("hold_ctl", {out_valid, out_SC}, {1'b1, 5'd4});
            chk("hold_cnt", out_stall_cnt, 1);
        end

        // release hold: hazard taken, then reset while in LU_STALL
        in_hold = 0;
        tick();
        chk("haz2_cnt", out_stall_cnt, 2);
        chk("haz2_valid", out_valid, 0);
        #1 chk("lus_mask", out_stall, 0);
        in_reset = 1;
        #1 chk("rst2_stall", out_stall, 0);
        tick();
        chk("rst2_cnt", out_stall_cnt, 0);
        chk("rst2_out", {out_A, out_B, out_valid}, 0);
        in_reset = 0;
        #1 chk("rst2_run", out_stall, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
